cam_capture: RTL and testbench
==============================

CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter IMG_W, default 160: active pixels per line.
REQ-002 Parameter IMG_H, default 120: active lines per frame.
REQ-003 Parameter ADDR_W, default 15: frame-buffer address width; 2^ADDR_W SHALL be at least IMG_W*IMG_H.
REQ-004 clk  input  1  system clock; the only clock; all state on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 pclk  input  1  camera pixel clock, sampled as data (not a clock).
REQ-007 href  input  1  camera line-valid; high during active bytes.
REQ-008 vsync  input  1  camera frame sync; high between frames.
REQ-009 px_data  input  8  camera byte bus, RGB565, high byte first.
REQ-010 start  input  1  one-cycle request from the Wishbone camera block to capture one frame.
REQ-011 mem_addr  output  ADDR_W  frame-buffer write address.
REQ-012 mem_data  output  8  RGB332 pixel.
REQ-013 mem_we  output  1  frame-buffer write strobe, one clk per pixel.
REQ-014 busy  output  1  high from accepted start until frame end.
REQ-015 done  output  1  sticky frame-complete flag, cleared by the next accepted start.
REQ-016 overflow  output  1  sticky; set when pixels exceed IMG_W*IMG_H; cleared by the next accepted start.

Function
REQ-017 pclk, href, vsync and px_data SHALL each pass through a 2-flop synchronizer into clk.
REQ-018 A pclk rising edge SHALL be detected as synchronized pclk=1 with its previous sample=0; clk SHALL be at least 4x the pclk frequency.
REQ-019 FSM states SHALL be IDLE, WAIT_VS_HI, WAIT_VS_LO, CAPTURE.
REQ-020 IDLE: start=1 -> WAIT_VS_HI; busy=1; done=0; overflow=0; mem_addr=0; byte phase=0.
REQ-021 WAIT_VS_HI -> WAIT_VS_LO when synchronized vsync=1.
REQ-022 WAIT_VS_LO -> CAPTURE when synchronized vsync=0, so capture always begins at a frame boundary.
REQ-023 CAPTURE: each detected pclk edge with synchronized href=1 SHALL latch one byte and toggle byte phase.
REQ-024 Phase 0 byte SHALL be stored as the high byte (R[4:0], G[5:3]); phase 1 byte is the low byte (G[2:0], B[4:0]).
REQ-025 On each phase 1 byte: mem_data={R[4:2],G[5:3],B[4:3]}; mem_we=1 for exactly the next clk cycle with the current mem_addr; mem_addr increments after that cycle.
REQ-026 Latency SHALL be one clk from the detected edge of the phase 1 byte to mem_we high.
REQ-027 Synchronized href=0 SHALL reset byte phase to 0; an unpaired byte is discarded with no write.
REQ-028 When mem_addr = IMG_W*IMG_H, further pixels SHALL NOT be written, mem_addr holds, and overflow is set.
REQ-029 Synchronized vsync=1 in CAPTURE SHALL end the frame -> IDLE; done=1; busy=0 on the same clk.
REQ-030 Frame end and a final pixel write in the same cycle SHALL complete the write before done rises.
REQ-031 start while busy=1 SHALL be ignored.
REQ-032 start in the same cycle as frame end SHALL be ignored; done stays 1.
REQ-033 mem_we SHALL be 0 in every state except the write cycle of REQ-025.

Reset
REQ-034 rst=0 SHALL asynchronously force: FSM=IDLE, mem_addr=0, mem_data=0, mem_we=0, busy=0, done=0, overflow=0, byte phase=0, and all synchronizer flops=0.
REQ-035 Reset during CAPTURE SHALL abort the frame with no further writes; operation resumes only on a new start after rst=1.

Verification
REQ-036 start, then vsync 1->0, 4 lines x 2 px, bytes 0xF8,0x1F -> 8 writes, addr 0..7, mem_data=0xE3, done=1 after vsync rises.
REQ-037 href drops after 3 bytes -> exactly 1 write; next line starts at phase 0.
REQ-038 IMG_W=4, IMG_H=2 with 10 px sent -> writes at addr 0..7 only; overflow=1; mem_addr=8.
REQ-039 start asserted with vsync already low mid-frame -> no writes until vsync completes a 1->0 cycle.
REQ-040 rst=0 pulsed mid-line -> all outputs 0 immediately; a later start captures from addr 0.
REQ-041 Second start while busy -> ignored; a start after done -> done=0, busy=1.

Source files
------------

// File: rtl/cam_capture.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cam_capture: captures one RGB565 camera frame and writes it as RGB332 pixels
// Rev 1.0
// -----------------------------------------------------------------------------
module cam_capture #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pclk,
    input  logic              href,
    input  logic              vsync,
    input  logic [7:0]        px_data,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_VS_HI = 2'd1,
        WAIT_VS_LO = 2'd2,
        CAPTURE    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] c_NPIX = (ADDR_W+1)'(IMG_W * IMG_H);

    logic              pclk_s1_q, pclk_s2_q, pclk_prev_q;
    logic              href_s1_q, href_s2_q;
    logic              vsync_s1_q, vsync_s2_q;
    logic [7:0]        px_s1_q, px_s2_q;

    state_t            state_q;
    logic              phase_q;
    logic [5:0]        hi_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_data_q;
    logic              mem_we_q;
    logic              busy_q;
    logic              done_q;
    logic              overflow_q;

    logic              pclk_rise;
    logic              byte_take;
    logic              full;
    logic              pix_wr;
    logic [7:0]        rgb332_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pclk_s1_q   <= 1'b0;
            pclk_s2_q   <= 1'b0;
            pclk_prev_q <= 1'b0;
            href_s1_q   <= 1'b0;
            href_s2_q   <= 1'b0;
            vsync_s1_q  <= 1'b0;
            vsync_s2_q  <= 1'b0;
            px_s1_q     <= 8'h00;
            px_s2_q     <= 8'h00;
        end else begin
            pclk_s1_q   <= pclk;
            pclk_s2_q   <= pclk_s1_q;
            pclk_prev_q <= pclk_s2_q;
            href_s1_q   <= href;
            href_s2_q   <= href_s1_q;
            vsync_s1_q  <= vsync;
            vsync_s2_q  <= vsync_s1_q;
            px_s1_q     <= px_data;
            px_s2_q     <= px_s1_q;
        end
    end

    assign pclk_rise = pclk_s2_q & ~pclk_prev_q;
    assign byte_take = (state_q == CAPTURE) && pclk_rise && href_s2_q;
    assign full      = ({1'b0, mem_addr_q} >= c_NPIX);
    assign pix_wr    = byte_take && phase_q && !full;
    // Only the RGB565 bits that survive the RGB332 reduction are kept.
    assign rgb332_d  = {hi_q, px_s2_q[4:3]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            phase_q    <= 1'b0;
            hi_q       <= 6'h00;
            mem_addr_q <= '0;
            mem_data_q <= 8'h00;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (mem_we_q) begin
                mem_addr_q <= mem_addr_q + ADDR_W'(1);
            end
            if (!href_s2_q) begin
                phase_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= WAIT_VS_HI;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        overflow_q <= 1'b0;
                        mem_addr_q <= '0;
                        phase_q    <= 1'b0;
                    end
                end
                WAIT_VS_HI: begin
                    if (vsync_s2_q) state_q <= WAIT_VS_LO;
                end
                WAIT_VS_LO: begin
                    if (!vsync_s2_q) state_q <= CAPTURE;
                end
                CAPTURE: begin
                    if (byte_take) begin
                        phase_q <= ~phase_q;
                        if (!phase_q) begin
                            hi_q <= {px_s2_q[7:5], px_s2_q[2:0]};
                        end else if (full) begin
                            overflow_q <= 1'b1;
                        end else begin
                            mem_we_q   <= 1'b1;
                            mem_data_q <= rgb332_d;
                        end
                    end
                    // A write issued this cycle holds off frame end by one clk.
                    if (vsync_s2_q && !pix_wr) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_we   = mem_we_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_capture.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_cam_capture: randomized self-checking bench for cam_capture
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_cam_capture;

    localparam int c_W  = 4;
    localparam int c_H  = 2;
    localparam int c_AW = 4;
    localparam int c_N  = c_W * c_H;

    logic            clk     = 1'b0;
    logic            rst     = 1'b0;
    logic            pclk    = 1'b0;
    logic            href    = 1'b0;
    logic            vsync   = 1'b0;
    logic            start   = 1'b0;
    logic [7:0]      px_data = 8'h00;
    logic [c_AW-1:0] mem_addr;
    logic [7:0]      mem_data;
    logic            mem_we;
    logic            busy;
    logic            done;
    logic            overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame-level view of what the capture should produce.
    bit         m_busy, m_done, m_ovf, m_seenhi, m_cap, m_phase;
    int         m_cnt;
    logic [7:0] m_hi;
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;

    cam_capture #(
        .IMG_W  (c_W),
        .IMG_H  (c_H),
        .ADDR_W (c_AW)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .pclk     (pclk),
        .href     (href),
        .vsync    (vsync),
        .px_data  (px_data),
        .start    (start),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rgb332(input logic [7:0] hi, input logic [7:0] lo);
        int r, g, b;
        r = int'(hi) >> 3;
        g = ((int'(hi) & 7) << 3) | (int'(lo) >> 5);
        b = int'(lo) & 31;
        return 8'(((r >> 2) << 5) | ((g >> 3) << 2) | (b >> 3));
    endfunction

    always @(negedge clk) begin
        if (rst && mem_we) begin
            if (exp_q.size() == 0) begin
                chk("we_unexpected", 32'(mem_we), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(mon_e[15:8]));
                chk("wr_data", 32'(mem_data), 32'(mon_e[7:0]));
            end
        end
    end

    task automatic check_status(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(m_busy));
        chk({tag, "_done"}, 32'(done), 32'(m_done));
        chk({tag, "_ovf"},  32'(overflow), 32'(m_ovf));
        chk({tag, "_addr"}, 32'(mem_addr), 32'(m_cnt));
    endtask

    task automatic model_frame_end();
        if (m_cap) begin
            m_cap  = 1'b0;
            m_busy = 1'b0;
            m_done = 1'b1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (!m_busy) begin
            m_busy   = 1'b1;
            m_done   = 1'b0;
            m_ovf    = 1'b0;
            m_cnt    = 0;
            m_cap    = 1'b0;
            m_phase  = 1'b0;
            m_seenhi = vsync;
        end
        check_status("start");
    endtask

    task automatic set_vsync(input logic v);
        vsync = v;
        repeat (4) @(posedge clk);
        #1;
        if (v) begin
            if (m_cap) model_frame_end();
            else if (m_busy) m_seenhi = 1'b1;
        end else if (m_busy && m_seenhi) begin
            m_cap = 1'b1;
        end
        check_status("vsync");
    endtask

    task automatic send_byte(input logic [7:0] b, input bit vs_with);
        bit exp_we = 1'b0;
        if (m_cap && href) begin
            if (!m_phase) begin
                m_hi    = b;
                m_phase = 1'b1;
            end else begin
                m_phase = 1'b0;
                if (m_cnt < c_N) begin
                    exp_q.push_back({8'(m_cnt), rgb332(m_hi, b)});
                    m_cnt++;
                    exp_we = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        px_data = b;
        repeat ($urandom_range(2, 4)) @(posedge clk);
        #1 pclk = 1'b1;
        if (vs_with) vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("we_latency", 32'(mem_we), 32'(exp_we));
        if (vs_with) chk("done_before_wr", 32'(done), 32'd0);
        @(posedge clk);
        #1 chk("we_single", 32'(mem_we), 32'd0);
        if (vs_with) begin
            model_frame_end();
            chk("done_after_wr", 32'(done), 32'(m_done));
        end
        pclk = 1'b0;
    endtask

    task automatic send_line(input int npx, input bit odd, input bit fixed, input bit vs_last);
        logic [7:0] h, l;
        href = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < npx; i++) begin
            h = fixed ? 8'hF8 : 8'($urandom);
            l = fixed ? 8'h1F : 8'($urandom);
            send_byte(h, 1'b0);
            send_byte(l, vs_last && !odd && (i == npx - 1));
        end
        if (odd) send_byte(8'($urandom), 1'b0);
        href = 1'b0;
        repeat (3) @(posedge clk);
        #1 m_phase = 1'b0;
    endtask

    task automatic end_with_start();
        vsync = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 model_frame_end();
        check_status("end_start");
    endtask

    task automatic frame_drained(input string tag);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_status("reset");
        chk("reset_we",   32'(mem_we),   32'd0);
        chk("reset_data", 32'(mem_data), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame: 4 lines x 2 px of 0xF8,0x1F.
        do_start();
        set_vsync(1'b1);
        set_vsync(1'b0);
        repeat (4) send_line(2, 1'b0, 1'b1, 1'b0);
        set_vsync(1'b1);
        frame_drained("basic_drained");

        // Restart after done, ignored start while busy, unpaired byte.
        do_start();
        set_vsync(1'b0);
        send_line(2, 1'b0, 1'b0, 1'b0);
        do_start();
        send_line(1, 1'b1, 1'b0, 1'b0);
        send_line(2, 1'b0, 1'b0, 1'b0);
        set_vsync(1'b1);
        frame_drained("busy_drained");

        // Start with vsync already low mid-frame; start coincident with frame end.
        set_vsync(1'b0);
        do_start();
        send_line(2, 1'b0, 1'b0, 1'b0);
        set_vsync(1'b1);
        set_vsync(1'b0);
        send_line(2, 1'b0, 1'b0, 1'b0);
        end_with_start();
        frame_drained("midframe_drained");

        // Overflow: 10 px into an 8 px frame.
        do_start();
        set_vsync(1'b0);
        send_line(4, 1'b0, 1'b0, 1'b0);
        send_line(4, 1'b0, 1'b0, 1'b0);
        send_line(2, 1'b0, 1'b0, 1'b0);
        set_vsync(1'b1);
        frame_drained("ovf_drained");

        // Final pixel and frame end arriving together.
        do_start();
        set_vsync(1'b0);
        send_line(1, 1'b0, 1'b0, 1'b1);
        check_status("vs_wr");
        frame_drained("vs_wr_drained");

        // Reset mid-line, then a clean capture from address 0.
        do_start();
        set_vsync(1'b0);
        href = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", 32'(mem_data), 32'd0);
        chk("rst_we",   32'(mem_we),   32'd0);
        chk("rst_busy", 32'(busy),     32'd0);
        chk("rst_done", 32'(done),     32'd0);
        chk("rst_ovf",  32'(overflow), 32'd0);
        href = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_seenhi = 1'b0;
        m_cap = 1'b0; m_phase = 1'b0; m_cnt = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        do_start();
        set_vsync(1'b1);
        set_vsync(1'b0);
        send_line(2, 1'b0, 1'b0, 1'b0);
        set_vsync(1'b1);
        frame_drained("rst_drained");

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            do_start();
            set_vsync(1'b1);
            set_vsync(1'b0);
            for (int ln = 0; ln < int'($urandom_range(1, 4)); ln++) begin
                send_line(int'($urandom_range(0, 4)), $urandom_range(0, 3) == 0, 1'b0, 1'b0);
                if ($urandom_range(0, 3) == 0) do_start();
            end
            set_vsync(1'b1);
            frame_drained("rand_drained");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
